tpu_share_arbiter: RTL and testbench
====================================

# tpu_share_arbiter

Arbiter between the two fully-connected layer engines (full_connect1, full_connect2) and the two resources they share: the weight ROM (block_mem) and the combinational 128-lane TPU_MultAdd. It replaces per-layer tri-state muxing with a registered, round-robin ownership grant, so the idle requester always sees driven zeros. The ROM read pipeline is drained before ownership passes to the other requester. It sits in TPU_Control between the layer engines and the shared resources; the top-level sequencer only drives the layers' enables and resets.

## Interface
- BIT, 16: element width; MultAdd result width is 2*BIT-1.
- LANES, 128: operand lanes per MultAdd call / ROM word.
- AW, 11: ROM address width.

- clk  in  1  system clock
- iRst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes all state
- req1, req2  in  1  requester wants ownership (held for the whole layer)
- addr1, addr2  in  AW  requester ROM address
- rd1, rd2  in  1  requester read strobe
- opa1, opb1, opa2, opb2  in  LANES*BIT  MultAdd operands per requester
- gnt1, gnt2  out  1  ownership grant, registered
- rom_en  out  1  ROM read enable
- rom_addr  out  AW  ROM address
- rom_dout  in  LANES*BIT  ROM data, one cycle after rom_en
- rdata1, rdata2  out  LANES*BIT  ROM data to requester (zero if not owner of that read)
- rvalid1, rvalid2  out  1  rdata valid pulse
- ma_opa, ma_opb  out  LANES*BIT  shared MultAdd operands
- ma_res  in  2*BIT-1  MultAdd result
- ma_ovf  in  1  MultAdd overflow
- res1, res2  out  2*BIT-1  result to owner, zero otherwise
- ovf1, ovf2  out  1  sticky overflow per requester
- busy  out  1  any grant or handoff in progress

## Operation
- States: IDLE, OWN1, OWN2, DRAIN. Reset -> IDLE; last_owner = 2, so req1 wins the first tie.
- IDLE: if only one req is high, go to its OWNx. If both are high, grant the one that is not last_owner. No req: stay.
- OWNx: gntx = 1. rom_addr = addrx and rom_en = rdx & ena, both combinational from the owner. ma_opa/ma_opb = owner operands; resx = ma_res.
- OWNx when reqx falls -> DRAIN; last_owner <= x.
- A req from the non-owner during OWNx is ignored until handoff.
- DRAIN: exactly one cycle. No grant, rom_en = 0, ma operands = 0. Then IDLE-style selection is applied on the next cycle; DRAIN never grants directly.
- ROM read tag: a registered owner id accompanies each rom_en. The cycle after, rvalid/rdata go to the tagged requester. This holds even if the requester has already dropped req (read issued in the last OWN cycle, delivered during DRAIN).
- Non-owner outputs: rdata, res, rvalid all zero; no Z anywhere.
- ovfx: set when ownerx and ma_ovf; cleared on the IDLE->OWNx transition that grants x; holds otherwise.
- ena low: state, tags, sticky flags frozen. rom_en = 0, rvalid = 0. Grants hold their values.
- No operand arithmetic is performed in this block; widths pass through unchanged.

## Timing
- Reset values: gnt1 = gnt2 = 0, rom_en = 0, rom_addr = 0, rvalid* = 0, rdata* = 0, res* = 0, ovf* = 0, busy = 0.
- Grant latency: req high at edge N (state IDLE) -> gnt high after edge N+1.
- Release: req low at edge N -> gnt low after N+1 (DRAIN). The other requester's grant comes no earlier than after N+2.
- ROM: rom_en at cycle N -> rvalid at N+1 (block_mem 1-cycle read).
- MultAdd path: combinational through the block; no added latency.
- Reset asserted mid-ownership: all outputs drop to reset values asynchronously. In-flight ROM read is discarded (no rvalid).

## Structure
- Shared package tpu_pkg: BIT, LANES, AW, and the state encoding localparams (IDLE=2'd0, OWN1=2'd1, OWN2=2'd2, DRAIN=2'd3), reused by TPU_Control.
- One sub-module, rr_pick2: 2-way round-robin selector (req1, req2, last_owner -> pick, valid).
- Output muxing and the tag register stay in the top module.

## Test plan
- Reset, then req1 = 1 only: gnt1 = 1 one cycle later. addr1 = 11'h005, rd1 pulse -> rom_addr = 5, rvalid1 next cycle with rdata1 = ROM[5]; rdata2 = 0.
- req1 and req2 rise in the same cycle after reset: gnt1 first. Drop req1: one DRAIN cycle with busy = 1 and no grant, then gnt2.
- Handoff with in-flight read: rd1 asserted in the cycle req1 falls -> rvalid1 in the DRAIN cycle, rvalid2 stays 0.
- Owner 2 with ma_ovf = 1 for one cycle: ovf2 stays 1 through release. The next grant to 2 clears it; ovf1 is unaffected.
- Reset asserted while OWN2 with a read pending: gnt2, rom_en, rvalid2 go 0 immediately; after release, req2 alone is granted after one cycle.
- ena low for 3 cycles during OWN1 with rd1 high: rom_en = 0, no rvalid, gnt1 held. Operation resumes unchanged when ena returns high.

Source files
------------

// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the TPU control slice: element width, lane count,
// ROM address width and the ownership state encoding used by the shared
// resource arbiter (and reused by TPU_Control).
// ---------------------------------------------------------------------------
package tpu_pkg;

  // Element width; the MultAdd result is 2*BIT-1 bits wide.
  localparam int BIT   = 16;
  // Operand lanes per MultAdd call and per ROM word.
  localparam int LANES = 128;
  // Weight ROM address width.
  localparam int AW    = 11;
  // Convenience widths derived from the above.
  localparam int DW    = LANES * BIT;
  localparam int RW    = 2 * BIT - 1;

  // Ownership state of the shared ROM / MultAdd pair.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN1  = 2'd1,
    OWN2  = 2'd2,
    DRAIN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tpu_share_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Two-way round-robin selector. When both requesters are asking, the one
// that did not own the resources last wins; otherwise the single active
// requester wins.
//   req1_i, req2_i  request lines
//   last_owner_i    0 = requester 1 owned last, 1 = requester 2 owned last
//   pick_o          0 = grant requester 1, 1 = grant requester 2
//   valid_o         at least one request is present
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic req1_i,
  input  logic req2_i,
  input  logic last_owner_i,
  output logic pick_o,
  output logic valid_o
);

  // On a tie, alternate away from the previous owner.
  always_comb begin
    valid_o = req1_i | req2_i;
    pick_o  = (req1_i & req2_i) ? ~last_owner_i : req2_i;
  end

endmodule

// File: rtl/tpu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tpu_share_arbiter
// Grants exclusive, registered ownership of the weight ROM and the shared
// 128-lane MultAdd to one of the two fully-connected layer engines. The idle
// requester always sees driven zeros. One DRAIN cycle separates owners so a
// ROM read issued in the last owned cycle is still delivered to its issuer.
//   clk, iRst_n           clock, asynchronous active-low reset
//   ena                   global enable; low freezes all state
//   req1/2                ownership requests (held for a whole layer)
//   addr1/2, rd1/2        per-requester ROM address and read strobe
//   opa1/opb1/opa2/opb2   per-requester MultAdd operands
//   gnt1/2                ownership grants
//   rom_en, rom_addr      ROM read port; rom_dout arrives one cycle later
//   rdata1/2, rvalid1/2   ROM data routed to the requester that issued it
//   ma_opa, ma_opb        shared MultAdd operands; ma_res/ma_ovf come back
//   res1/2                MultAdd result to the owner, zero otherwise
//   ovf1/2                sticky overflow per requester
//   busy                  ownership or handoff in progress
// ---------------------------------------------------------------------------
module tpu_share_arbiter
  import tpu_pkg::*;
(
  input  logic          clk,
  input  logic          iRst_n,
  input  logic          ena,
  input  logic          req1,
  input  logic          req2,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] addr2,
  input  logic          rd1,
  input  logic          rd2,
  input  logic [DW-1:0] opa1,
  input  logic [DW-1:0] opb1,
  input  logic [DW-1:0] opa2,
  input  logic [DW-1:0] opb2,
  output logic          gnt1,
  output logic          gnt2,
  output logic          rom_en,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_dout,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2,
  output logic          rvalid1,
  output logic          rvalid2,
  output logic [DW-1:0] ma_opa,
  output logic [DW-1:0] ma_opb,
  input  logic [RW-1:0] ma_res,
  input  logic          ma_ovf,
  output logic [RW-1:0] res1,
  output logic [RW-1:0] res2,
  output logic          ovf1,
  output logic          ovf2,
  output logic          busy
);

  arb_state_e state_q, state_d;
  logic       lastOwner_q, lastOwner_d;
  logic       ovf1_q, ovf1_d;
  logic       ovf2_q, ovf2_d;
  logic       rdPend_q;
  logic       rdTag_q;
  logic       pick;
  logic       pickValid;
  logic       own1;
  logic       own2;

  rr_pick2 u_pick (
    .req1_i       (req1),
    .req2_i       (req2),
    .last_owner_i (lastOwner_q),
    .pick_o       (pick),
    .valid_o      (pickValid)
  );

  // State, round-robin history and sticky overflow flags. Requester 2 is
  // recorded as the last owner at reset so requester 1 wins the first tie.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      lastOwner_q <= 1'b1;
      ovf1_q      <= 1'b0;
      ovf2_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lastOwner_q <= lastOwner_d;
      ovf1_q      <= ovf1_d;
      ovf2_q      <= ovf2_d;
    end
  end

  // Next-state logic. Everything holds while ena is low. DRAIN always
  // returns to IDLE so a new owner is only ever selected from IDLE.
  always_comb begin
    state_d     = state_q;
    lastOwner_d = lastOwner_q;
    ovf1_d      = ovf1_q;
    ovf2_d      = ovf2_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (pickValid) begin
            if (pick) begin
              state_d = OWN2;
              ovf2_d  = 1'b0;
            end else begin
              state_d = OWN1;
              ovf1_d  = 1'b0;
            end
          end
        end
        OWN1: begin
          if (ma_ovf) ovf1_d = 1'b1;
          if (!req1) begin
            state_d     = DRAIN;
            lastOwner_d = 1'b0;
          end
        end
        OWN2: begin
          if (ma_ovf) ovf2_d = 1'b1;
          if (!req2) begin
            state_d     = DRAIN;
            lastOwner_d = 1'b1;
          end
        end
        DRAIN:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Each ROM read carries the id of the owner that issued it, so the data
  // returned a cycle later reaches that requester even if it has already
  // released ownership. Reset discards any read in flight.
  always_ff @(posedge clk or negedge iRst_n) begin
    if (!iRst_n) begin
      rdPend_q <= 1'b0;
      rdTag_q  <= 1'b0;
    end else if (ena) begin
      rdPend_q <= rom_en;
      rdTag_q  <= own2;
    end
  end

  // Output steering: the owner drives the shared resources, the non-owner
  // and the DRAIN/IDLE states see zeros.
  always_comb begin
    own1     = (state_q == OWN1);
    own2     = (state_q == OWN2);
    gnt1     = own1;
    gnt2     = own2;
    busy     = (state_q != IDLE);
    rom_en   = ena & ((own1 & rd1) | (own2 & rd2));
    rom_addr = '0;
    ma_opa   = '0;
    ma_opb   = '0;
    if (own1) begin
      rom_addr = addr1;
      ma_opa   = opa1;
      ma_opb   = opb1;
    end else if (own2) begin
      rom_addr = addr2;
      ma_opa   = opa2;
      ma_opb   = opb2;
    end
    res1    = own1 ? ma_res : '0;
    res2    = own2 ? ma_res : '0;
    rvalid1 = ena & rdPend_q & ~rdTag_q;
    rvalid2 = ena & rdPend_q & rdTag_q;
    rdata1  = rvalid1 ? rom_dout : '0;
    rdata2  = rvalid2 ? rom_dout : '0;
    ovf1    = ovf1_q;
    ovf2    = ovf2_q;
  end

endmodule

// File: tb/tb_tpu_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tpu_share_arbiter
// Directed self-checking bench for tpu_share_arbiter. A one-cycle ROM model
// returns a recognisable word per address; MultAdd results are driven as
// constants by the bench.
// ---------------------------------------------------------------------------
module tb_tpu_share_arbiter;
  import tpu_pkg::*;

  logic          clk;
  logic          iRst_n;
  logic          ena;
  logic          req1, req2;
  logic [AW-1:0] addr1, addr2;
  logic          rd1, rd2;
  logic [DW-1:0] opa1, opb1, opa2, opb2;
  logic          gnt1, gnt2;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_dout;
  logic [DW-1:0] rdata1, rdata2;
  logic          rvalid1, rvalid2;
  logic [DW-1:0] ma_opa, ma_opb;
  logic [RW-1:0] ma_res;
  logic          ma_ovf;
  logic [RW-1:0] res1, res2;
  logic          ovf1, ovf2;
  logic          busy;

  int passCount;
  int checkCount;

  tpu_share_arbiter dut (
    .clk      (clk),
    .iRst_n   (iRst_n),
    .ena      (ena),
    .req1     (req1),
    .req2     (req2),
    .addr1    (addr1),
    .addr2    (addr2),
    .rd1      (rd1),
    .rd2      (rd2),
    .opa1     (opa1),
    .opb1     (opb1),
    .opa2     (opa2),
    .opb2     (opb2),
    .gnt1     (gnt1),
    .gnt2     (gnt2),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .rvalid1  (rvalid1),
    .rvalid2  (rvalid2),
    .ma_opa   (ma_opa),
    .ma_opb   (ma_opb),
    .ma_res   (ma_res),
    .ma_ovf   (ma_ovf),
    .res1     (res1),
    .res2     (res2),
    .ovf1     (ovf1),
    .ovf2     (ovf2),
    .busy     (busy)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every ROM word is one 16-bit value, 16'hA000 + address, in all lanes.
  function automatic logic [DW-1:0] romWord(input logic [AW-1:0] a);
    logic [BIT-1:0] w;
    w = 16'hA000 + 16'(a);
    return {LANES{w}};
  endfunction

  // Behavioural block_mem: one-cycle registered read.
  always @(posedge clk) begin
    if (rom_en) rom_dout <= romWord(rom_addr);
  end

  // Compare one observed value with the expected one and tally the result.
  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    logic [DW-1:0] o;
    logic [DW-1:0] e;
    o = observed;
    e = expected;
    checkCount++;
    if (o === e) passCount++;
    else $display("[TB] FAIL %s: got %0h want %0h (low 64 bits)", tag, o[63:0], e[63:0]);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence; each expectation is worked out by hand from the
  // intended cycle behaviour.
  initial begin
    passCount = 0;
    checkCount = 0;
    iRst_n = 1'b0; ena = 1'b1;
    req1 = 1'b0; req2 = 1'b0; rd1 = 1'b0; rd2 = 1'b0;
    addr1 = '0; addr2 = '0;
    opa1 = {LANES{16'h1111}}; opb1 = {LANES{16'h2222}};
    opa2 = {LANES{16'h3333}}; opb2 = {LANES{16'h4444}};
    ma_res = 31'h1234_5678; ma_ovf = 1'b0;
    rom_dout = '0;
    #3;
    checkOutput("rst_gnt1", DW'(gnt1), DW'(1'b0));
    checkOutput("rst_gnt2", DW'(gnt2), DW'(1'b0));
    checkOutput("rst_rom_en", DW'(rom_en), DW'(1'b0));
    checkOutput("rst_rom_addr", DW'(rom_addr), '0);
    checkOutput("rst_busy", DW'(busy), DW'(1'b0));
    checkOutput("rst_res1", DW'(res1), '0);
    checkOutput("rst_ovf2", DW'(ovf2), DW'(1'b0));
    applyStimulus();
    iRst_n = 1'b1;
    applyStimulus();

    // Single requester 1: grant, then one ROM read of address 5.
    req1 = 1'b1;
    applyStimulus();
    checkOutput("t1_gnt1", DW'(gnt1), DW'(1'b1));
    checkOutput("t1_gnt2", DW'(gnt2), DW'(1'b0));
    checkOutput("t1_busy", DW'(busy), DW'(1'b1));
    addr1 = 11'h005; rd1 = 1'b1;
    #1;
    checkOutput("t1_rom_en", DW'(rom_en), DW'(1'b1));
    checkOutput("t1_rom_addr", DW'(rom_addr), DW'(11'h005));
    checkOutput("t1_ma_opa", ma_opa, {LANES{16'h1111}});
    checkOutput("t1_res1", DW'(res1), DW'(31'h1234_5678));
    checkOutput("t1_res2", DW'(res2), '0);
    applyStimulus();
    rd1 = 1'b0;
    checkOutput("t1_rvalid1", DW'(rvalid1), DW'(1'b1));
    checkOutput("t1_rdata1", rdata1, romWord(11'h005));
    checkOutput("t1_rdata2", rdata2, '0);
    checkOutput("t1_rvalid2", DW'(rvalid2), DW'(1'b0));
    applyStimulus();
    checkOutput("t1_rvalid1_off", DW'(rvalid1), DW'(1'b0));
    req1 = 1'b0;
    applyStimulus();
    applyStimulus();

    // Simultaneous requests after reset: requester 1 first, then handoff
    // with a read issued in requester 1's last owned cycle.
    iRst_n = 1'b0;
    #1;
    iRst_n = 1'b1;
    req1 = 1'b1; req2 = 1'b1;
    applyStimulus();
    checkOutput("t2_gnt1", DW'(gnt1), DW'(1'b1));
    checkOutput("t2_gnt2", DW'(gnt2), DW'(1'b0));
    applyStimulus();
    checkOutput("t2_hold_gnt2", DW'(gnt2), DW'(1'b0));
    addr1 = 11'h007; rd1 = 1'b1; req1 = 1'b0;
    #1;
    checkOutput("t2_last_rom_en", DW'(rom_en), DW'(1'b1));
    applyStimulus();
    checkOutput("t2_drain_gnt1", DW'(gnt1), DW'(1'b0));
    checkOutput("t2_drain_gnt2", DW'(gnt2), DW'(1'b0));
    checkOutput("t2_drain_busy", DW'(busy), DW'(1'b1));
    checkOutput("t2_drain_rom_en", DW'(rom_en), DW'(1'b0));
    checkOutput("t2_drain_ma_opa", ma_opa, '0);
    checkOutput("t2_drain_rvalid1", DW'(rvalid1), DW'(1'b1));
    checkOutput("t2_drain_rdata1", rdata1, romWord(11'h007));
    checkOutput("t2_drain_rvalid2", DW'(rvalid2), DW'(1'b0));
    rd1 = 1'b0;
    applyStimulus();
    checkOutput("t2_idle_gnt2", DW'(gnt2), DW'(1'b0));
    checkOutput("t2_idle_busy", DW'(busy), DW'(1'b0));
    applyStimulus();
    checkOutput("t2_own2_gnt2", DW'(gnt2), DW'(1'b1));
    checkOutput("t2_own2_ma_opb", ma_opb, {LANES{16'h4444}});

    // Overflow while requester 2 owns: sticky through release, cleared on
    // the next grant to 2, requester 1's flag untouched.
    ma_ovf = 1'b1;
    applyStimulus();
    ma_ovf = 1'b0;
    checkOutput("t3_ovf2_set", DW'(ovf2), DW'(1'b1));
    checkOutput("t3_ovf1_clear", DW'(ovf1), DW'(1'b0));
    checkOutput("t3_res2", DW'(res2), DW'(31'h1234_5678));
    checkOutput("t3_res1", DW'(res1), '0);
    req2 = 1'b0;
    applyStimulus();
    applyStimulus();
    checkOutput("t3_ovf2_held", DW'(ovf2), DW'(1'b1));
    req2 = 1'b1;
    applyStimulus();
    checkOutput("t3_regrant", DW'(gnt2), DW'(1'b1));
    checkOutput("t3_ovf2_cleared", DW'(ovf2), DW'(1'b0));
    checkOutput("t3_ovf1", DW'(ovf1), DW'(1'b0));

    // Reset during OWN2 with a read issued: everything drops at once and
    // the read is never delivered.
    addr2 = 11'h009; rd2 = 1'b1;
    #2;
    iRst_n = 1'b0;
    #1;
    checkOutput("t4_gnt2", DW'(gnt2), DW'(1'b0));
    checkOutput("t4_rom_en", DW'(rom_en), DW'(1'b0));
    checkOutput("t4_rvalid2", DW'(rvalid2), DW'(1'b0));
    rd2 = 1'b0;
    applyStimulus();
    checkOutput("t4_rvalid2_held", DW'(rvalid2), DW'(1'b0));
    iRst_n = 1'b1;
    applyStimulus();
    checkOutput("t4_regrant", DW'(gnt2), DW'(1'b1));
    checkOutput("t4_no_stale", DW'(rvalid2), DW'(1'b0));

    // ena low for three cycles while requester 1 reads continuously.
    iRst_n = 1'b0;
    #1;
    iRst_n = 1'b1;
    req2 = 1'b0; req1 = 1'b1;
    applyStimulus();
    addr1 = 11'h003; rd1 = 1'b1;
    applyStimulus();
    checkOutput("t5_pre_rvalid1", DW'(rvalid1), DW'(1'b1));
    ena = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("t5_frz_rom_en", DW'(rom_en), DW'(1'b0));
      checkOutput("t5_frz_rvalid1", DW'(rvalid1), DW'(1'b0));
      checkOutput("t5_frz_gnt1", DW'(gnt1), DW'(1'b1));
      applyStimulus();
    end
    ena = 1'b1;
    #1;
    checkOutput("t5_res_rom_en", DW'(rom_en), DW'(1'b1));
    checkOutput("t5_res_rvalid1", DW'(rvalid1), DW'(1'b1));
    checkOutput("t5_res_rdata1", rdata1, romWord(11'h003));
    checkOutput("t5_res_gnt1", DW'(gnt1), DW'(1'b1));
    rd1 = 1'b0; req1 = 1'b0;
    applyStimulus();
    checkOutput("t5_drain_gnt1", DW'(gnt1), DW'(1'b0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
